fetch_stage: RTL and testbench
==============================

# fetch_stage

Instruction-fetch stage of the five-stage pipeline: holds the program counter, addresses the instruction memory, and loads the IF/ID pipeline register. It consumes the next-PC target and branch/jump redirect flag produced by the ID-stage next-PC logic. It also honours hazard-unit stalls and buffers a redirect that arrives while fetch is stalled.

## Interface
Parameters:
- RESET_PC, 32'h0000_3000: PC value after reset; also pc_d reset value.

Ports:
- clk  in  1  pipeline clock, rising edge
- rst  in  1  synchronous, active-high reset
- stall  in  1  hazard-unit stall; freezes the PC and IF/ID
- npc  in  32  redirect target from ID-stage next-PC logic
- boj  in  1  redirect request (branch taken or jump) this cycle
- instr_in  in  32  instruction word from IM, combinational on pc_out
- pc_out  out  32  current fetch address to IM
- ir_d  out  32  IF/ID instruction
- pc_d  out  32  IF/ID PC of ir_d
- pc4_d  out  32  IF/ID pc_d + 4
- valid_d  out  1  IF/ID holds a real instruction (0 = bubble)
- adel  out  1  one-cycle pulse: redirect to a non-word-aligned target was applied

## Operation
- State: pc[31:0], pend_v, pend_tgt[31:0], IF/ID register (ir_d, pc_d, pc4_d, valid_d).
- Redirect source per cycle: boj ? npc : (pend_v ? pend_tgt : none). A live boj always wins over a buffered target.
- PC update:
  - rst: pc <= RESET_PC.
  - stall=1: pc holds.
  - Otherwise, with a redirect source: pc <= source.
  - Otherwise: pc <= pc + 4 (mod 2^32; 32'hFFFF_FFFC wraps to 0).
- Pending buffer:
  - rst clears pend_v; pend_tgt resets to 0.
  - boj while stall=1: pend_tgt <= npc, pend_v <= 1. A later boj during the same stall overwrites pend_tgt.
  - Any cycle with stall=0: pend_v <= 0.
- IF/ID:
  - rst: ir_d=0 (nop), pc_d=RESET_PC, pc4_d=RESET_PC+4, valid_d=0.
  - stall=1: hold all fields.
  - stall=0 with no redirect source: load instr_in, pc, pc+4, valid_d=1.
  - stall=0 with a redirect source: behaviour per DELAY_SLOT_EN (see Configuration).
- Alignment check:
  - Applied target with bits [1:0] != 0: the PC still takes the target unmodified.
  - adel pulses high for the cycle after the update; it resets to 0.
- pc_out = pc (register output, no combinational path from inputs).

## Timing
- Fetch latency: the instruction at address A appears on ir_d one cycle after pc_out=A, provided stall=0.
- Redirect: boj with stall=0 in cycle N gives pc_out=npc in cycle N+1 and its instruction on ir_d in N+2.
- Redirect during stall: boj in any stalled cycle is applied in the first cycle with stall=0. It takes effect on pc_out one cycle later.
- Simultaneous stall deassertion and new boj: the new npc is used and the buffer is discarded.
- rst dominates stall and boj in the same cycle. Reset mid-stall discards any pending redirect.
- All outputs are registered. No combinational input-to-output paths.

## Configuration
- DELAY_SLOT_EN defined (MIPS delay-slot semantics): on a redirect cycle, IF/ID loads the instruction at the current pc normally, with valid_d=1.
- DELAY_SLOT_EN undefined: on a redirect cycle, IF/ID loads a bubble (ir_d=0, valid_d=0, pc_d/pc4_d hold). The sequentially fetched instruction is squashed.

## Test plan
- Reset then 3 free cycles, IM returning 32'h1111_0000+addr: pc_out goes 3000, 3004, 3008; ir_d=1111_3000 with valid_d=1 one cycle after pc_out=3000.
- boj=1, npc=32'h0000_3100 with stall=0 while pc_out=3008:
  - next pc_out=3100.
  - With DELAY_SLOT_EN, ir_d=1111_3008 and valid_d=1.
  - Without DELAY_SLOT_EN, ir_d=0 and valid_d=0.
- stall=1 for 3 cycles with boj pulse npc=3200 in stall cycle 2, boj=0 afterwards: pc_out and ir_d frozen; after release pc_out=3200.
- Stalled with pending 3200, stall drops in the same cycle as boj npc=3300: next pc_out=3300, pend_v=0.
- boj npc=32'h0000_3102: pc_out=3102 and adel=1 for exactly one cycle.
- Assert rst during a stall with pend_v=1: pc_out=3000, valid_d=0, and no later redirect to the buffered target.

Source files
------------

// File: rtl/fetch_stage.sv
// Instruction-fetch stage: PC register, IM addressing, IF/ID register and a
// one-entry buffer for redirects that arrive during a stall. Option: DELAY_SLOT_EN.
module fetch_stage #(
  parameter logic [31:0] RESET_PC = 32'h0000_3000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        stall,
  input  logic [31:0] npc,
  input  logic        boj,
  input  logic [31:0] instr_in,
  output logic [31:0] pc_out,
  output logic [31:0] ir_d,
  output logic [31:0] pc_d,
  output logic [31:0] pc4_d,
  output logic        valid_d,
  output logic        adel
);

  logic [31:0] pc_reg;
  logic        pend_v_reg;
  logic [31:0] pend_tgt_reg;
  logic [31:0] ir_d_reg;
  logic [31:0] pc_d_reg;
  logic [31:0] pc4_d_reg;
  logic        valid_d_reg;
  logic        adel_reg;

  logic        redir_v_next;
  logic [31:0] redir_tgt_next;
  logic [31:0] pc_plus4_next;

  // A live redirect always beats one buffered during an earlier stall.
  always_comb begin
    redir_v_next   = boj | pend_v_reg;
    redir_tgt_next = boj ? npc : pend_tgt_reg;
    pc_plus4_next  = pc_reg + 32'd4;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pc_reg       <= RESET_PC;
      pend_v_reg   <= 1'b0;
      pend_tgt_reg <= 32'h0;
      ir_d_reg     <= 32'h0;
      pc_d_reg     <= RESET_PC;
      pc4_d_reg    <= RESET_PC + 32'd4;
      valid_d_reg  <= 1'b0;
      adel_reg     <= 1'b0;
    end else begin
      adel_reg <= 1'b0;
      if (stall) begin
        if (boj) begin
          pend_v_reg   <= 1'b1;
          pend_tgt_reg <= npc;
        end
      end else begin
        pend_v_reg <= 1'b0;
        if (redir_v_next) begin
          pc_reg   <= redir_tgt_next;
          adel_reg <= |redir_tgt_next[1:0];
`ifdef DELAY_SLOT_EN
          ir_d_reg    <= instr_in;
          pc_d_reg    <= pc_reg;
          pc4_d_reg   <= pc_plus4_next;
          valid_d_reg <= 1'b1;
`else
          // Squash the sequential fetch; pc_d/pc4_d keep their old values.
          ir_d_reg    <= 32'h0;
          valid_d_reg <= 1'b0;
`endif
        end else begin
          pc_reg      <= pc_plus4_next;
          ir_d_reg    <= instr_in;
          pc_d_reg    <= pc_reg;
          pc4_d_reg   <= pc_plus4_next;
          valid_d_reg <= 1'b1;
        end
      end
    end
  end

  assign pc_out  = pc_reg;
  assign ir_d    = ir_d_reg;
  assign pc_d    = pc_d_reg;
  assign pc4_d   = pc4_d_reg;
  assign valid_d = valid_d_reg;
  assign adel    = adel_reg;

endmodule

// File: tb/tb_fetch_stage.sv
// Directed bench for fetch_stage; IM model returns 32'h1111_0000 + address.
module tb_fetch_stage;

  logic        clk = 1'b0;
  logic        rst;
  logic        stall;
  logic [31:0] npc;
  logic        boj;
  logic [31:0] instr_in;
  logic [31:0] pc_out;
  logic [31:0] ir_d;
  logic [31:0] pc_d;
  logic [31:0] pc4_d;
  logic        valid_d;
  logic        adel;

  int tests = 0;
  int fails = 0;

  fetch_stage dut (
    .clk(clk), .rst(rst), .stall(stall), .npc(npc), .boj(boj),
    .instr_in(instr_in), .pc_out(pc_out), .ir_d(ir_d), .pc_d(pc_d),
    .pc4_d(pc4_d), .valid_d(valid_d), .adel(adel)
  );

  always #5 clk = ~clk;
  assign instr_in = 32'h1111_0000 + pc_out;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end else begin
      $display("ok   %s: %h", tag, got);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1; stall = 1'b0; boj = 1'b0; npc = 32'h0;
    step();
    rst = 1'b0;
    check("rst_pc", pc_out, 32'h0000_3000);
    check("rst_ir", ir_d, 32'h0);
    check("rst_pc_d", pc_d, 32'h0000_3000);
    check("rst_pc4_d", pc4_d, 32'h0000_3004);
    check("rst_valid", {31'b0, valid_d}, 32'd0);
    check("rst_adel", {31'b0, adel}, 32'd0);

    step();
    check("seq1_pc", pc_out, 32'h0000_3004);
    check("seq1_ir", ir_d, 32'h1111_3000);
    check("seq1_valid", {31'b0, valid_d}, 32'd1);
    check("seq1_pc_d", pc_d, 32'h0000_3000);
    step();
    check("seq2_pc", pc_out, 32'h0000_3008);
    check("seq2_ir", ir_d, 32'h1111_3004);

    // Unstalled redirect
    boj = 1'b1; npc = 32'h0000_3100;
    step();
    boj = 1'b0;
    check("br_pc", pc_out, 32'h0000_3100);
`ifdef DELAY_SLOT_EN
    check("br_ir", ir_d, 32'h1111_3008);
    check("br_valid", {31'b0, valid_d}, 32'd1);
    check("br_pc_d", pc_d, 32'h0000_3008);
`else
    check("br_ir", ir_d, 32'h0);
    check("br_valid", {31'b0, valid_d}, 32'd0);
    check("br_pc_d", pc_d, 32'h0000_3004);
`endif
    check("br_adel", {31'b0, adel}, 32'd0);
    step();
    check("br2_pc", pc_out, 32'h0000_3104);
    check("br2_ir", ir_d, 32'h1111_3100);
    check("br2_valid", {31'b0, valid_d}, 32'd1);

    // Three-cycle stall with a redirect in cycle 2
    stall = 1'b1;
    step();
    check("st1_pc", pc_out, 32'h0000_3104);
    check("st1_ir", ir_d, 32'h1111_3100);
    boj = 1'b1; npc = 32'h0000_3200;
    step();
    boj = 1'b0;
    check("st2_pc", pc_out, 32'h0000_3104);
    step();
    check("st3_pc", pc_out, 32'h0000_3104);
    check("st3_ir", ir_d, 32'h1111_3100);
    stall = 1'b0;
    step();
    check("pend_pc", pc_out, 32'h0000_3200);
`ifdef DELAY_SLOT_EN
    check("pend_ir", ir_d, 32'h1111_3104);
`else
    check("pend_valid", {31'b0, valid_d}, 32'd0);
`endif
    step();
    check("pend2_pc", pc_out, 32'h0000_3204);
    check("pend2_ir", ir_d, 32'h1111_3200);

    // Buffered 3400 discarded by a live redirect on stall release
    stall = 1'b1; boj = 1'b1; npc = 32'h0000_3400;
    step();
    stall = 1'b0; boj = 1'b1; npc = 32'h0000_3300;
    step();
    boj = 1'b0;
    check("live_pc", pc_out, 32'h0000_3300);
    step();
    check("live2_pc", pc_out, 32'h0000_3304);

    // Later boj in the same stall overwrites the buffer
    stall = 1'b1; boj = 1'b1; npc = 32'h0000_3600;
    step();
    npc = 32'h0000_3700;
    step();
    boj = 1'b0; stall = 1'b0;
    step();
    check("ovr_pc", pc_out, 32'h0000_3700);

    // Misaligned target
    boj = 1'b1; npc = 32'h0000_3102;
    step();
    boj = 1'b0;
    check("adel_pc", pc_out, 32'h0000_3102);
    check("adel_hi", {31'b0, adel}, 32'd1);
    step();
    check("adel_pc2", pc_out, 32'h0000_3106);
    check("adel_lo", {31'b0, adel}, 32'd0);

    // Reset during a stall with a pending redirect
    stall = 1'b1; boj = 1'b1; npc = 32'h0000_3500;
    step();
    boj = 1'b0; rst = 1'b1;
    step();
    rst = 1'b0; stall = 1'b0;
    check("rstst_pc", pc_out, 32'h0000_3000);
    check("rstst_valid", {31'b0, valid_d}, 32'd0);
    step();
    check("rstst2_pc", pc_out, 32'h0000_3004);
    check("rstst2_ir", ir_d, 32'h1111_3000);

    // PC wrap at the top of the address space
    boj = 1'b1; npc = 32'hFFFF_FFFC;
    step();
    boj = 1'b0;
    check("wrap_pc0", pc_out, 32'hFFFF_FFFC);
    step();
    check("wrap_pc1", pc_out, 32'h0000_0000);
    check("wrap_ir", ir_d, 32'h1110_FFFC);
    check("wrap_pc_d", pc_d, 32'hFFFF_FFFC);
    check("wrap_pc4_d", pc4_d, 32'h0000_0000);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
